occupancy_map_ram: RTL and testbench
====================================

Name: occupancy_map_ram

Overview:
Parametrised occupancy-grid memory for the map stage. It stores one signed log-odds word per cell and serves two request types from the scan matcher through a valid/ready port. The first is a saturating read-modify-write update of one cell. The second is a 2x2 neighbourhood fetch, used for bilinear interpolation. Map size and word size are parameters; the defaults match the existing 128x32, 8-bit map geometry.

Parameters:
WORD_SIZE, 8, bits per cell, signed two's complement log-odds
WIDTH, 128, cells in x
HEIGHT, 32, cells in y
DELTA_WIDTH, 8, bits of signed update increment
XW = $clog2(WIDTH), YW = $clog2(HEIGHT), derived localparams, not overridable

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block accepts a request this cycle
req_op  in  2  00 = neighbourhood read, 01 = update, 10 = clear map, 11 = reserved (accepted, no effect, no response)
req_x  in  XW  cell x
req_y  in  YW  cell y
req_delta  in  DELTA_WIDTH  signed increment, used only by update
rsp_valid  out  1  neighbourhood data valid
rsp_ready  in  1  consumer takes the response
rsp_data  out  4*WORD_SIZE  packing from LSB: [0] = (x,y), [1] = (x+1,y), [2] = (x,y+1), [3] = (x+1,y+1)
busy  out  1  high in any state other than IDLE

Behaviour:
- Storage: WIDTH*HEIGHT words, single port, synchronous read with 1-cycle latency. Address = y*WIDTH + x.
- Reset: async assert gives state = INIT_CLEAR, req_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 1. Memory contents are not reset.
- INIT_CLEAR: after rst deasserts, the block writes 0 to one cell per cycle in ascending address order, taking WIDTH*HEIGHT cycles, then goes to IDLE.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. req_ready = (state == IDLE) && !rsp_valid. Request fields are captured at acceptance.
- States: IDLE, INIT_CLEAR, CLEAR, NB_READ, NB_RESP, UPD_READ, UPD_WRITE.
- Clear (op 10): same sequence as INIT_CLEAR, then IDLE. A clear takes exactly WIDTH*HEIGHT cycles.
- Update (op 01):
  - UPD_READ issues the read of (x,y).
  - UPD_WRITE computes sum = sign-extend(old) + sign-extend(delta) at max(WORD_SIZE, DELTA_WIDTH)+1 bits.
  - The sum saturates to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1] and is written back.
  - req_ready is high again 3 cycles after the accepting edge.
  - Back-to-back updates to the same cell must see the previous write; the read follows the write by at least one cycle, so no forwarding path is needed.
- Neighbourhood read (op 00):
  - NB_READ issues four reads in packing order, one per cycle.
  - Any neighbour with x+1 >= WIDTH or y+1 >= HEIGHT is not read and its lane is 0.
  - rsp_valid rises 5 cycles after the accepting edge, with all four lanes registered.
  - rsp_valid and rsp_data hold stable until the edge where rsp_ready = 1. rsp_valid then clears and the state returns to IDLE.
  - rsp_ready is ignored while rsp_valid = 0.
- Out-of-range x >= WIDTH or y >= HEIGHT (only possible for non-power-of-two sizes):
  - Update: no write, normal timing.
  - Read: lane reads 0.
- Reset mid-operation aborts the operation immediately. A partial update does not write. Then INIT_CLEAR runs.
- busy = (state != IDLE).

Test Plan:
- Reset, then release -> busy and req_ready = 0 for 4096 cycles (default); then req_ready = 1; a read of (5,3) returns rsp_data = 0.
- Update (10,4) delta +100 twice -> cell = 127 (saturated); update delta -128 three times -> cell = -128; the 4th read shows 0x80.
- Write (0,0) = 1, (1,0) = 2, (0,1) = 3, (1,1) = 4, then read (0,0) -> rsp_data = 0x04030201, rsp_valid exactly 5 cycles after acceptance.
- Read (127,31) after setting it to 7 -> rsp_data = 0x00000007; hold rsp_ready low 10 cycles -> data stable, req_ready = 0 throughout.
- Back-to-back updates to (2,2) with delta +1 on every allowed cycle, 20 times -> final read lane 0 = 20.
- Assert rst during UPD_WRITE of (6,6) delta +50 on a cell preset to 10 -> after INIT_CLEAR, read (6,6) = 0. Then issue clear op -> busy exactly 4096 cycles.

Source files
------------

// File: rtl/occupancy_map_ram.sv
// Occupancy-grid log-odds store: saturating cell update, 2x2 neighbourhood fetch and full-map clear.
// Single-port synchronous RAM; updates take 3 cycles, neighbourhood responses arrive 5 cycles after acceptance.
module occupancy_map_ram #(
  parameter int WORD_SIZE   = 8,
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 32,
  parameter int DELTA_WIDTH = 8,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [XW-1:0]            req_x,
  input  logic [YW-1:0]            req_y,
  input  logic [DELTA_WIDTH-1:0]   req_delta,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [4*WORD_SIZE-1:0]   rsp_data,
  output logic                     busy
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int AW    = $clog2(CELLS);
  localparam int SW    = ((WORD_SIZE > DELTA_WIDTH) ? WORD_SIZE : DELTA_WIDTH) + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

  localparam logic [1:0] OP_NB    = 2'b00;
  localparam logic [1:0] OP_UPD   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    INIT_CLEAR,
    CLEAR,
    NB_READ,
    NB_RESP,
    UPD_READ,
    UPD_WRITE
  } state_t;

  state_t                         state;
  logic [AW-1:0]                  clr_addr;
  logic [XW-1:0]                  x_q;
  logic [YW-1:0]                  y_q;
  logic signed [DELTA_WIDTH-1:0]  delta_q;
  logic [2:0]                     nb_cnt;
  logic                           upd_ph;
  logic [WORD_SIZE-1:0]           sum_q;

  logic [WORD_SIZE-1:0]           mem [CELLS];
  logic [WORD_SIZE-1:0]           rd_q;

  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] cx, input logic [YW-1:0] cy);
    return AW'(int'(cy) * WIDTH + int'(cx));
  endfunction

  // Neighbour coordinates carry one extra bit so x+1 / y+1 at the map edge is detectable.
  logic [XW:0] x_ext, x_p1;
  logic [YW:0] y_ext, y_p1;
  logic        x_ok, x1_ok, y_ok, y1_ok;
  logic [3:0]  lane_ok;

  always_comb begin
    x_ext   = {1'b0, x_q};
    y_ext   = {1'b0, y_q};
    x_p1    = x_ext + 1'b1;
    y_p1    = y_ext + 1'b1;
    x_ok    = x_ext < (XW+1)'(WIDTH);
    y_ok    = y_ext < (YW+1)'(HEIGHT);
    x1_ok   = x_p1  < (XW+1)'(WIDTH);
    y1_ok   = y_p1  < (YW+1)'(HEIGHT);
    lane_ok = {x1_ok && y1_ok, x_ok && y1_ok, x1_ok && y_ok, x_ok && y_ok};
  end

  logic [XW-1:0]        rd_x;
  logic [YW-1:0]        rd_y;
  logic [AW-1:0]        rd_addr;
  logic                 rd_en;
  logic [AW-1:0]        wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 we;
  logic                 clearing;

  always_comb begin
    rd_x = x_q;
    rd_y = y_q;
    if (state == NB_READ) begin
      if (nb_cnt[0]) rd_x = x_p1[XW-1:0];
      if (nb_cnt[1]) rd_y = y_p1[YW-1:0];
    end
    rd_addr  = cell_addr(rd_x, rd_y);
    rd_en    = ((state == UPD_READ) && lane_ok[0]) ||
               ((state == NB_READ) && !nb_cnt[2] && lane_ok[nb_cnt[1:0]]);
    clearing = (state == INIT_CLEAR) || (state == CLEAR);
    wr_addr  = clearing ? clr_addr : cell_addr(x_q, y_q);
    wr_data  = clearing ? '0 : sum_q;
    we       = !rst && (clearing || ((state == UPD_WRITE) && upd_ph && lane_ok[0]));
  end

  // Disabled reads return zero so out-of-range neighbour lanes fall out naturally.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_q <= rd_en ? mem[rd_addr] : '0;
  end

  logic signed [SW-1:0]        sum;
  logic        [WORD_SIZE-1:0] sat;

  always_comb begin
    sum = SW'($signed(rd_q)) + SW'(delta_q);
    if (sum > SAT_MAX)      sat = SAT_MAX[WORD_SIZE-1:0];
    else if (sum < SAT_MIN) sat = SAT_MIN[WORD_SIZE-1:0];
    else                    sat = sum[WORD_SIZE-1:0];
  end

  logic [1:0] cap_lane;
  assign cap_lane = nb_cnt[1:0] - 2'd1;

  assign req_ready = (state == IDLE) && !rsp_valid;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT_CLEAR;
      clr_addr  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      delta_q   <= '0;
      nb_cnt    <= '0;
      upd_ph    <= 1'b0;
      sum_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            x_q     <= req_x;
            y_q     <= req_y;
            delta_q <= req_delta;
            case (req_op)
              OP_NB: begin
                nb_cnt <= '0;
                state  <= NB_READ;
              end
              OP_UPD: begin
                upd_ph <= 1'b0;
                state  <= UPD_READ;
              end
              OP_CLEAR: begin
                clr_addr <= '0;
                state    <= CLEAR;
              end
              default: state <= IDLE;
            endcase
          end
        end
        INIT_CLEAR, CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == AW'(CELLS - 1)) state <= IDLE;
        end
        // Lane k is addressed at count k and captured from rd_q at count k+1.
        NB_READ: begin
          nb_cnt <= nb_cnt + 3'd1;
          if (nb_cnt != 3'd0) rsp_data[cap_lane*WORD_SIZE +: WORD_SIZE] <= rd_q;
          if (nb_cnt == 3'd4) begin
            rsp_valid <= 1'b1;
            state     <= NB_RESP;
          end
        end
        NB_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        UPD_READ: begin
          upd_ph <= 1'b0;
          state  <= UPD_WRITE;
        end
        // Phase 0 registers the saturated sum, phase 1 commits it to the RAM.
        UPD_WRITE: begin
          if (!upd_ph) begin
            sum_q  <= sat;
            upd_ph <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_map_ram.sv
// Directed bench for occupancy_map_ram at the default 128x32, 8-bit geometry.
module tb_occupancy_map_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [6:0]  req_x = '0;
  logic [4:0]  req_y = '0;
  logic [7:0]  req_delta = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  occupancy_map_ram dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_delta (req_delta),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [6:0] x, input logic [4:0] y, input logic [7:0] d);
    int n = 0;
    while (!req_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    req_delta = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic upd(input logic [6:0] x, input logic [4:0] y, input logic [7:0] d, output int lat);
    send(2'b01, x, y, d);
    lat = 0;
    while (!req_ready && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic nb_read(input logic [6:0] x, input logic [4:0] y, output logic [31:0] data, output int lat);
    send(2'b00, x, y, 8'h00);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    data = rsp_data;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 5000) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset;
    int cnt;
    int lat;
    logic [31:0] d;
    #3 rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, req_ready, rsp_valid} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags: busy/req_ready/rsp_valid=%b required 100", {busy, req_ready, rsp_valid});
    end
    tests++;
    if (rsp_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_rsp_data: got %h required 00000000", rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    count_busy(cnt);
    tests++;
    if (cnt !== 4096) begin
      fails++;
      $display("FAIL init_clear_cycles: got %0d required 4096", cnt);
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_init: got %b required 1", req_ready);
    end
    nb_read(7'd5, 5'd3, d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL read_after_init: got %h required 00000000", d);
    end
  endtask

  task automatic test_saturate;
    int lat;
    logic [31:0] d;
    upd(7'd10, 5'd4, 8'd100, lat);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL update_latency: got %0d required 3", lat);
    end
    upd(7'd10, 5'd4, 8'd100, lat);
    nb_read(7'd10, 5'd4, d, lat);
    tests++;
    if (d !== 32'h0000007f) begin
      fails++;
      $display("FAIL sat_positive: got %h required 0000007f", d);
    end
    for (int i = 0; i < 3; i++) upd(7'd10, 5'd4, 8'h80, lat);
    nb_read(7'd10, 5'd4, d, lat);
    tests++;
    if (d !== 32'h00000080) begin
      fails++;
      $display("FAIL sat_negative: got %h required 00000080", d);
    end
  endtask

  task automatic test_pack;
    int lat;
    logic [31:0] d;
    upd(7'd0, 5'd0, 8'd1, lat);
    upd(7'd1, 5'd0, 8'd2, lat);
    upd(7'd0, 5'd1, 8'd3, lat);
    upd(7'd1, 5'd1, 8'd4, lat);
    nb_read(7'd0, 5'd0, d, lat);
    tests++;
    if (d !== 32'h04030201) begin
      fails++;
      $display("FAIL nb_packing: got %h required 04030201", d);
    end
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL nb_latency: got %0d required 5", lat);
    end
  endtask

  task automatic test_edge_hold;
    int lat;
    int n;
    logic [31:0] d;
    upd(7'd127, 5'd0, 8'd5, lat);
    upd(7'd127, 5'd1, 8'd9, lat);
    nb_read(7'd127, 5'd0, d, lat);
    tests++;
    if (d !== 32'h00090005) begin
      fails++;
      $display("FAIL right_edge: got %h required 00090005", d);
    end
    upd(7'd127, 5'd31, 8'd7, lat);
    send(2'b00, 7'd127, 5'd31, 8'h00);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({rsp_valid, req_ready, rsp_data} !== {1'b1, 1'b0, 32'h00000007}) begin
        fails++;
        $display("FAIL hold_cycle_%0d: valid/ready/data=%b/%b/%h required 1/0/00000007",
                 i, rsp_valid, req_ready, rsp_data);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      fails++;
      $display("FAIL hold_release: valid/ready/busy=%b required 010", {rsp_valid, req_ready, busy});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] d;
    for (int i = 0; i < 20; i++) upd(7'd2, 5'd2, 8'd1, lat);
    nb_read(7'd2, 5'd2, d, lat);
    tests++;
    if (d !== 32'h00000014) begin
      fails++;
      $display("FAIL back_to_back: got %h required 00000014", d);
    end
  endtask

  task automatic test_reserved;
    send(2'b11, 7'd20, 5'd20, 8'h00);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    tests++;
    if ({busy, rsp_valid, req_ready} !== 3'b001) begin
      fails++;
      $display("FAIL reserved_op: busy/rsp_valid/req_ready=%b required 001", {busy, rsp_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int cnt;
    logic [31:0] d;
    upd(7'd6, 5'd6, 8'd10, lat);
    nb_read(7'd6, 5'd6, d, lat);
    tests++;
    if (d !== 32'h0000000a) begin
      fails++;
      $display("FAIL preset_cell: got %h required 0000000a", d);
    end
    send(2'b01, 7'd6, 5'd6, 8'd50);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL mid_reset_flags: busy/req_ready=%b required 10", {busy, req_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    count_busy(cnt);
    tests++;
    if (cnt !== 4096) begin
      fails++;
      $display("FAIL mid_reset_init_cycles: got %0d required 4096", cnt);
    end
    nb_read(7'd6, 5'd6, d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL aborted_update: got %h required 00000000", d);
    end
    nb_read(7'd0, 5'd0, d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL init_wipes_map: got %h required 00000000", d);
    end
  endtask

  task automatic test_clear;
    int lat;
    int cnt;
    logic [31:0] d;
    upd(7'd6, 5'd6, 8'd5, lat);
    upd(7'd127, 5'd31, 8'd3, lat);
    send(2'b10, 7'd0, 5'd0, 8'h00);
    count_busy(cnt);
    tests++;
    if (cnt !== 4096) begin
      fails++;
      $display("FAIL clear_cycles: got %0d required 4096", cnt);
    end
    nb_read(7'd6, 5'd6, d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL clear_cell: got %h required 00000000", d);
    end
    nb_read(7'd127, 5'd31, d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL clear_last_cell: got %h required 00000000", d);
    end
  endtask

  initial begin
    test_reset;
    test_saturate;
    test_pack;
    test_edge_hold;
    test_back_to_back;
    test_reserved;
    test_reset_mid;
    test_clear;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
